// File: rtl/sequential_multiplier_radix.sv
// Multi-cycle shift-and-add multiplier that retires BITS_PER_CYCLE multiplier bits per cycle.
// Signed operands go through magnitude form, and the product sign is applied on the final step.
module sequential_multiplier_radix #(
  parameter int DATA_WIDTH_A   = 8,
  parameter int DATA_WIDTH_B   = 8,
  parameter int DATA_WIDTH_C   = DATA_WIDTH_A + DATA_WIDTH_B,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic [DATA_WIDTH_A-1:0] i_a,
  input  logic [DATA_WIDTH_B-1:0] i_b,
  input  logic                    i_signed,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [DATA_WIDTH_C-1:0] o_c,
  output logic                    o_valid,
  input  logic                    i_ready
);

  localparam int STEPS = DATA_WIDTH_A / BITS_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Magnitude of an operand; the most-negative value maps onto itself, read as unsigned.
  function automatic logic [DATA_WIDTH_A-1:0] mag_a(input logic [DATA_WIDTH_A-1:0] v,
                                                    input logic sgn);
    if (sgn && v[DATA_WIDTH_A-1]) begin
      mag_a = ~v + DATA_WIDTH_A'(1'b1);
    end else begin
      mag_a = v;
    end
  endfunction

  function automatic logic [DATA_WIDTH_B-1:0] mag_b(input logic [DATA_WIDTH_B-1:0] v,
                                                    input logic sgn);
    if (sgn && v[DATA_WIDTH_B-1]) begin
      mag_b = ~v + DATA_WIDTH_B'(1'b1);
    end else begin
      mag_b = v;
    end
  endfunction

  state_t                  state_q, state_d;
  logic [DATA_WIDTH_A-1:0] a_q, a_d;
  logic [DATA_WIDTH_C-1:0] b_sh_q, b_sh_d;
  logic [DATA_WIDTH_C-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    neg_q, neg_d;
  logic [DATA_WIDTH_C-1:0] c_q, c_d;
  logic                    valid_q, valid_d;
  logic                    ready_q, ready_d;
  logic [DATA_WIDTH_C-1:0] pp_s;
  logic [DATA_WIDTH_C-1:0] sum_s;

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= ST_IDLE;
      a_q     <= {DATA_WIDTH_A{1'b0}};
      b_sh_q  <= {DATA_WIDTH_C{1'b0}};
      acc_q   <= {DATA_WIDTH_C{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      neg_q   <= 1'b0;
      c_q     <= {DATA_WIDTH_C{1'b0}};
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      c_q     <= c_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic. The multiplicand is pre-shifted each step, so the partial product needs no variable shift.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    c_d     = c_q;
    valid_d = valid_q;
    pp_s    = DATA_WIDTH_C'(a_q[BITS_PER_CYCLE-1:0]) * b_sh_q;
    sum_s   = acc_q + pp_s;

    case (state_q)
      ST_IDLE: begin
        if (i_valid && ready_q) begin
          state_d = ST_MUL;
          a_d     = mag_a(i_a, i_signed);
          b_sh_d  = DATA_WIDTH_C'(mag_b(i_b, i_signed));
          acc_d   = {DATA_WIDTH_C{1'b0}};
          cnt_d   = CNT_W'(STEPS - 1);
          neg_d   = i_signed & (i_a[DATA_WIDTH_A-1] ^ i_b[DATA_WIDTH_B-1]);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_d  = sum_s;
        a_d    = a_q >> BITS_PER_CYCLE;
        b_sh_d = b_sh_q << BITS_PER_CYCLE;
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          if (neg_q) begin
            c_d = ~sum_s + DATA_WIDTH_C'(1'b1);
          end else begin
            c_d = sum_s;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1'b1);
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_c     = c_q;

endmodule

// File: tb/tb_sequential_multiplier_radix.sv
// Directed self-checking bench: K=2 instance for the main cases, K=1 instance for the radix-2 cases.
module tb_sequential_multiplier_radix;

  logic        i_clk;
  logic        i_nrst;
  logic [7:0]  a1, b1, a2, b2;
  logic        sgn1, sgn2, v1, v2, rdy1, rdy2;
  logic        or1, or2, ov1, ov2;
  logic [15:0] c1, c2;

  int n_checks;
  int n_pass;

  sequential_multiplier_radix #(.DATA_WIDTH_A(8), .DATA_WIDTH_B(8), .BITS_PER_CYCLE(2)) u_dut_k2 (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_a(a1), .i_b(b1), .i_signed(sgn1), .i_valid(v1),
    .o_ready(or1), .o_c(c1), .o_valid(ov1), .i_ready(rdy1)
  );

  sequential_multiplier_radix #(.DATA_WIDTH_A(8), .DATA_WIDTH_B(8), .BITS_PER_CYCLE(1)) u_dut_k1 (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_a(a2), .i_b(b2), .i_signed(sgn2), .i_valid(v2),
    .o_ready(or2), .o_c(c2), .o_valid(ov2), .i_ready(rdy2)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_valid(input int sel);
    return (sel == 1) ? ov2 : ov1;
  endfunction

  function automatic logic cur_ready(input int sel);
    return (sel == 1) ? or2 : or1;
  endfunction

  function automatic logic [15:0] cur_c(input int sel);
    return (sel == 1) ? c2 : c1;
  endfunction

  task automatic drive(input int sel, input logic [7:0] a, input logic [7:0] b,
                       input logic sgn, input logic v);
    if (sel == 1) begin
      a2 = a; b2 = b; sgn2 = sgn; v2 = v;
    end else begin
      a1 = a; b1 = b; sgn1 = sgn; v1 = v;
    end
  endtask

  // Counts rising edges until o_valid is seen, sampling 1 time unit after each edge.
  task automatic wait_valid(input int sel, output int lat);
    lat = 0;
    while (!cur_valid(sel) && lat < 40) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
  endtask

  // One full operation with downstream always ready.
  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic sgn,
                        input logic [15:0] exp, input int steps, input string tag);
    int lat;
    @(negedge i_clk);
    drive(sel, a, b, sgn, 1'b1);
    check_eq({tag, "_ready_before"}, 32'(cur_ready(sel)), 32'd1);
    @(posedge i_clk);
    #1;
    drive(sel, 8'hA5, 8'h5A, ~sgn, 1'b0);
    wait_valid(sel, lat);
    check_eq({tag, "_latency"}, 32'(lat), 32'(steps));
    check_eq({tag, "_product"}, 32'(cur_c(sel)), 32'(exp));
    @(posedge i_clk);
    #1;
    check_eq({tag, "_valid_drop"}, 32'(cur_valid(sel)), 32'd0);
    check_eq({tag, "_ready_back"}, 32'(cur_ready(sel)), 32'd1);
    check_eq({tag, "_c_retained"}, 32'(cur_c(sel)), 32'(exp));
  endtask

  initial begin
    int lat;
    int seen;
    n_checks = 0;
    n_pass   = 0;
    i_nrst   = 1'b0;
    drive(0, 8'd0, 8'd0, 1'b0, 1'b0);
    drive(1, 8'd0, 8'd0, 1'b0, 1'b0);
    rdy1 = 1'b1;
    rdy2 = 1'b1;
    #12;
    check_eq("rst_ready", 32'(or1), 32'd1);
    check_eq("rst_valid", 32'(ov1), 32'd0);
    check_eq("rst_c", 32'(c1), 32'd0);
    check_eq("rst_ready_k1", 32'(or2), 32'd1);
    @(negedge i_clk);
    i_nrst = 1'b1;

    // Unsigned and signed products, including the most-negative operand.
    run_op(0, 8'd255, 8'd255, 1'b0, 16'hFE01, 4, "u255x255");
    run_op(0, 8'h80, 8'h80, 1'b1, 16'h4000, 4, "s80x80");
    run_op(0, 8'hFD, 8'd5, 1'b1, 16'hFFF1, 4, "sm3x5");
    run_op(0, 8'hFD, 8'd5, 1'b0, 16'h04F1, 4, "uFDx5");
    run_op(0, 8'h7F, 8'h80, 1'b1, 16'hC080, 4, "s127xm128");

    // Back-pressure: the result holds for 10 cycles and a stray request is ignored.
    @(negedge i_clk);
    rdy1 = 1'b0;
    drive(0, 8'd100, 8'd3, 1'b0, 1'b1);
    @(posedge i_clk);
    #1;
    drive(0, 8'd0, 8'd0, 1'b0, 1'b0);
    wait_valid(0, lat);
    check_eq("bp_latency", 32'(lat), 32'd4);
    check_eq("bp_product", 32'(c1), 32'h012C);
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk);
      #1;
      if (i == 3) drive(0, 8'd1, 8'd1, 1'b0, 1'b1);
      else        drive(0, 8'd0, 8'd0, 1'b0, 1'b0);
      check_eq("bp_hold_valid", 32'(ov1), 32'd1);
      check_eq("bp_hold_c", 32'(c1), 32'h012C);
      check_eq("bp_hold_ready", 32'(or1), 32'd0);
    end
    @(negedge i_clk);
    rdy1 = 1'b1;
    @(posedge i_clk);
    #1;
    check_eq("bp_release_valid", 32'(ov1), 32'd0);
    check_eq("bp_release_ready", 32'(or1), 32'd1);
    seen = 0;
    repeat (8) begin
      @(posedge i_clk);
      #1;
      if (ov1) seen++;
    end
    check_eq("bp_no_second_result", 32'(seen), 32'd0);

    // Request held high across two operations: accepts must be 6 cycles apart.
    @(negedge i_clk);
    drive(0, 8'd3, 8'd7, 1'b0, 1'b1);
    @(posedge i_clk);
    #1;
    drive(0, 8'd12, 8'd12, 1'b0, 1'b1);
    wait_valid(0, lat);
    check_eq("b2b_latency1", 32'(lat), 32'd4);
    check_eq("b2b_product1", 32'(c1), 32'd21);
    check_eq("b2b_ready_at4", 32'(or1), 32'd0);
    @(posedge i_clk);
    #1;
    check_eq("b2b_ready_at5", 32'(or1), 32'd1);
    @(posedge i_clk);
    #1;
    check_eq("b2b_accept_at6", 32'(or1), 32'd0);
    drive(0, 8'd0, 8'd0, 1'b0, 1'b0);
    wait_valid(0, lat);
    check_eq("b2b_latency2", 32'(lat), 32'd4);
    check_eq("b2b_product2", 32'(c1), 32'd144);
    @(posedge i_clk);
    #1;

    // Reset during the second MUL cycle discards the operation.
    @(negedge i_clk);
    drive(0, 8'd50, 8'd50, 1'b0, 1'b1);
    @(posedge i_clk);
    #1;
    drive(0, 8'd0, 8'd0, 1'b0, 1'b0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_nrst = 1'b0;
    #1;
    check_eq("mrst_valid", 32'(ov1), 32'd0);
    check_eq("mrst_c", 32'(c1), 32'd0);
    check_eq("mrst_ready", 32'(or1), 32'd1);
    @(negedge i_clk);
    i_nrst = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge i_clk);
      #1;
      if (ov1) seen++;
    end
    check_eq("mrst_no_pulse", 32'(seen), 32'd0);
    run_op(0, 8'd9, 8'd9, 1'b0, 16'd81, 4, "after_rst_9x9");

    // Radix-2 instance: eight cycles per operation regardless of data.
    run_op(1, 8'd13, 8'd11, 1'b0, 16'd143, 8, "k1_13x11");
    run_op(1, 8'd0, 8'd200, 1'b0, 16'd0, 8, "k1_0x200");
    run_op(1, 8'h80, 8'hFF, 1'b1, 16'h0080, 8, "k1_sm128xm1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
